sha256_sched_ctrl: RTL and testbench
====================================

# sha256_sched_ctrl

Sequencer for the 16×32-bit SHA-256 message-schedule shift register. It accepts one 512-bit message block through a start/ready handshake and parallel-loads the block into the register. It then generates the expansion word W[t+16] every cycle from the register taps. It streams W[0..63] to the round datapath, one word per cycle, with round index and last/done markers. It sits between the block-input logic and the compression core.

## Interface
Parameters:
- CNT_W, 16, width of the completed-block counter (wraps modulo 2^CNT_W)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset, synchronous and active-low
- start  in  1  request to process msg_block; accepted when start && ready
- msg_block  in  512  message block, W0 = msg_block[511:480] … W15 = msg_block[31:0]
- abort  in  1  terminate current block
- ready  out  1  block can be accepted this cycle
- busy  out  1  rounds in progress
- w_valid  out  1  w_data/w_round valid this cycle
- w_round  out  6  round index t of w_data
- w_data  out  32  schedule word W[t]
- w_last  out  1  high with round 63
- done  out  1  one-cycle pulse after a block completes normally
- block_count  out  CNT_W  blocks completed since reset
- shf_load  out  1  to shifter load
- shf_parallel_in  out  512  to shifter parallel_in
- shf_shift_in  out  32  to shifter shift_in
- shf_tap_15, shf_tap_14, shf_tap_6, shf_tap_1  in  32 each  shifter stage outputs. Stage k holds W[t−1−k]; stage 0 is newest.

## Operation
- States: IDLE and RUN. A 6-bit round counter `rnd` is used in RUN only.
- IDLE: ready=1, busy=0. On start: shf_load=1 and go to RUN with rnd=0.
- RUN: busy=1 and w_valid=1.
  - w_round=rnd and w_data=shf_tap_15.
  - rnd increments each cycle.
  - At rnd=63: w_last=1 and ready=1 (back-to-back acceptance).
  - After rnd=63, go to RUN (rnd=0) if start was accepted that cycle, else go to IDLE.
- ready = (IDLE or (RUN and rnd==63)) and !abort.
- shf_load = start && ready (combinational).
- shf_parallel_in = msg_block, passed straight through with no reordering.
- shf_shift_in is always σ1(tap_1) + tap_6 + σ0(tap_14) + tap_15, modulo 2^32. Its value is don't-care outside RUN.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Non-blocking flow: the shifter advances every cycle it is not loaded, so no backpressure exists. The consumer must take one word per cycle.
- Outside RUN: w_data, w_round and w_last are driven 0.
- Normal completion (rnd=63 cycle, no abort):
  - done pulses the next cycle.
  - block_count increments the next cycle, wrapping from 2^CNT_W−1 to 0.
- abort in RUN, including at rnd=63:
  - next state is IDLE;
  - no done pulse, no count increment;
  - any start in that cycle is ignored.
- abort in IDLE has no effect.
- Priority: reset_n > abort > start.

## Timing
- Reset (reset_n low at a clock edge), all outputs after the edge:
  - state IDLE, rnd=0, ready=1, busy=0;
  - w_valid=0, w_round=0, w_data=0, w_last=0;
  - done=0, block_count=0, shf_load=0 (unless start is high).
- Reset mid-block discards the block. The next start after reset release is accepted normally.
- Let cycle C0 be the cycle with start && ready. Then:
  - W[t] appears in cycle C(1+t), for t = 0..63;
  - w_last is high in C64;
  - done is high in C65.
- Back-to-back blocks: start accepted in C64 gives W[0] of the next block in C65, with no bubble. done for the first block is also high in C65.
- Latency from block acceptance to first word is 1 cycle. Throughput is 64 cycles per block.

## Test plan
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018):
  - W0 in C1 and W15=0x00000018 in C16;
  - W16=0x61626380, W17=0x000F0000;
  - w_last and w_round=63 in C64, done in C65, block_count=1.
- Back-to-back: three blocks with start held high.
  - Expect 192 consecutive w_valid cycles, w_round wrapping 63→0.
  - Expect 3 done pulses; block_count=3.
- Abort at rnd=20:
  - w_valid drops the next cycle and state returns to IDLE;
  - no done pulse; block_count unchanged;
  - a new block then streams correctly from W0.
- Abort coincident with start at rnd=63: no shf_load, no done, IDLE afterwards, block_count unchanged.
- Reset asserted for one cycle at rnd=40:
  - all outputs at reset values after the edge;
  - start held during reset is not accepted;
  - a block after reset release completes with block_count=1.
- Random blocks: compare all 64 W[t] against a reference SHA-256 schedule model. Check block_count wraps to 0 after 2^CNT_W blocks, using CNT_W=4.

Source files
------------

// File: rtl/sha256_sched_ctrl.sv
// sha256_sched_ctrl: loads a 512-bit block into the external message-schedule shifter
// and streams W[0..63] with round index, last and done markers.
module sha256_sched_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [511:0]     msg_block,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic             w_valid,
   output logic [5:0]       w_round,
   output logic [31:0]      w_data,
   output logic             w_last,
   output logic             done,
   output logic [CNT_W-1:0] block_count,
   output logic             shf_load,
   output logic [511:0]     shf_parallel_in,
   output logic [31:0]      shf_shift_in,
   input  logic [31:0]      shf_tap_15,
   input  logic [31:0]      shf_tap_14,
   input  logic [31:0]      shf_tap_6,
   input  logic [31:0]      shf_tap_1
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [5:0] rnd, rnd_nx;
   logic run, last;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   assign run             = state == RUN;
   assign last            = run && rnd == 6'd63;
   assign busy            = run;
   assign w_valid         = run;
   assign w_round         = run ? rnd : 6'd0;
   assign w_data          = run ? shf_tap_15 : 32'd0;
   assign w_last          = last;
   assign shf_parallel_in = msg_block;
   assign shf_shift_in    = sig1(shf_tap_1) + shf_tap_6 + sig0(shf_tap_14) + shf_tap_15;

   // ready already excludes abort, so a load can never coincide with an abort
   always_comb begin
      ready    = (!run || rnd == 6'd63) && !abort;
      shf_load = start && ready;
      state_nx = state;
      rnd_nx   = rnd;
      if (shf_load) begin
         state_nx = RUN;
         rnd_nx   = 6'd0;
      end else if (run && (abort || last)) begin
         state_nx = IDLE;
         rnd_nx   = 6'd0;
      end else if (run)
         rnd_nx = rnd + 6'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         rnd         <= 6'd0;
         done        <= 1'b0;
         block_count <= '0;
      end else begin
         state <= state_nx;
         rnd   <= rnd_nx;
         done  <= last && !abort;
         if (last && !abort)
            block_count <= block_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb_sha256_sched_ctrl: directed checks of the schedule sequencer against a
// behavioural shifter and a reference SHA-256 message-schedule model.
module tb_sha256_sched_ctrl;
   localparam int CNT_W = 4;
   logic clk = 0, reset_n = 0, start = 0, abort = 0;
   logic [511:0] msg_block = '0;
   logic ready, busy, w_valid, w_last, done, shf_load;
   logic [5:0] w_round;
   logic [31:0] w_data, shf_shift_in;
   logic [CNT_W-1:0] block_count;
   logic [511:0] shf_parallel_in;
   logic [31:0] sr [16];
   logic [31:0] ref_w [64];
   logic [31:0] obs_w [64];
   logic [CNT_W-1:0] exp_cnt;
   logic [511:0] blks [3];
   int total = 0, bad = 0, vcount = 0;

   always #5 clk = ~clk;

   sha256_sched_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .msg_block(msg_block), .abort(abort),
      .ready(ready), .busy(busy), .w_valid(w_valid), .w_round(w_round), .w_data(w_data),
      .w_last(w_last), .done(done), .block_count(block_count), .shf_load(shf_load),
      .shf_parallel_in(shf_parallel_in), .shf_shift_in(shf_shift_in),
      .shf_tap_15(sr[15]), .shf_tap_14(sr[14]), .shf_tap_6(sr[6]), .shf_tap_1(sr[1])
   );

   // stage 0 newest; a load puts W0 in stage 15 and W15 in stage 0
   always @(posedge clk) begin
      if (shf_load)
         for (int k = 0; k < 16; k++) sr[k] <= shf_parallel_in[32*k +: 32];
      else begin
         sr[0] <= shf_shift_in;
         for (int k = 1; k < 16; k++) sr[k] <= sr[k-1];
      end
   end

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic gen_ref(input logic [511:0] b);
      for (int t = 0; t < 16; t++) ref_w[t] = b[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         ref_w[t] = (ror(ref_w[t-2], 17) ^ ror(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10)) + ref_w[t-7]
                  + (ror(ref_w[t-15], 7) ^ ror(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3)) + ref_w[t-16];
   endtask

   function automatic logic [511:0] rand_blk();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic send_block(input logic [511:0] b);
      msg_block = b;
      start = 1;
      #1 chk("send_load", shf_load, 1);
      cyc();
      start = 0;
   endtask

   task automatic stream_check(input string tag);
      for (int t = 0; t < 64; t++) begin
         if (t > 0) cyc();
         chk($sformatf("%s_valid%0d", tag, t), w_valid, 1);
         chk($sformatf("%s_round%0d", tag, t), w_round, t);
         chk($sformatf("%s_data%0d", tag, t), w_data, ref_w[t]);
         chk($sformatf("%s_last%0d", tag, t), w_last, t == 63);
         obs_w[t] = w_data;
         if (w_valid) vcount++;
      end
   endtask

   task automatic finish_check(input string tag);
      cyc();
      exp_cnt = exp_cnt + 1'b1;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_count"}, block_count, exp_cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_cnt = 0;
      cyc();
      cyc();
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", w_valid, 0);
      chk("rst_round", w_round, 0);
      chk("rst_data", w_data, 0);
      chk("rst_last", w_last, 0);
      chk("rst_done", done, 0);
      chk("rst_count", block_count, 0);
      chk("rst_load", shf_load, 0);
      reset_n = 1;
      cyc();
      chk("idle_busy", busy, 0);

      // abort in IDLE only masks ready for that cycle
      abort = 1;
      #1 chk("idle_abort_ready", ready, 0);
      cyc();
      abort = 0;
      #1 chk("idle_abort_busy", busy, 0);
      chk("idle_abort_ready_after", ready, 1);

      blks[0] = {32'h61626380, 448'h0, 32'h00000018};
      gen_ref(blks[0]);
      send_block(blks[0]);
      chk("abc_busy", busy, 1);
      stream_check("abc");
      chk("abc_w15", obs_w[15], 32'h00000018);
      chk("abc_w16", obs_w[16], 32'h61626380);
      chk("abc_w17", obs_w[17], 32'h000F0000);
      chk("abc_ready63", ready, 1);
      finish_check("abc");
      chk("abc_idle_valid", w_valid, 0);
      cyc();
      chk("abc_done_pulse", done, 0);

      for (int b = 0; b < 3; b++) blks[b] = rand_blk();
      vcount = 0;
      msg_block = blks[0];
      start = 1;
      cyc();
      for (int b = 0; b < 3; b++) begin
         gen_ref(blks[b]);
         if (b < 2) msg_block = blks[b+1];
         else start = 0;
         stream_check($sformatf("b2b%0d", b));
         #1 chk("b2b_ready63", ready, 1);
         chk("b2b_load63", shf_load, b < 2);
         finish_check("b2b");
      end
      chk("b2b_vcount", vcount, 192);
      chk("b2b_idle", w_valid, 0);
      cyc();
      chk("b2b_done_pulse", done, 0);

      blks[0] = rand_blk();
      gen_ref(blks[0]);
      send_block(blks[0]);
      for (int i = 0; i < 20; i++) cyc();
      chk("ab20_round", w_round, 20);
      chk("ab20_data", w_data, ref_w[20]);
      abort = 1;
      #1 chk("ab20_ready", ready, 0);
      cyc();
      abort = 0;
      chk("ab20_valid", w_valid, 0);
      chk("ab20_busy", busy, 0);
      chk("ab20_done", done, 0);
      cyc();
      chk("ab20_done2", done, 0);
      chk("ab20_count", block_count, exp_cnt);
      blks[0] = rand_blk();
      gen_ref(blks[0]);
      send_block(blks[0]);
      stream_check("post_ab20");
      finish_check("post_ab20");

      blks[0] = rand_blk();
      gen_ref(blks[0]);
      send_block(blks[0]);
      stream_check("ab63");
      start = 1;
      abort = 1;
      #1 chk("ab63_ready", ready, 0);
      chk("ab63_load", shf_load, 0);
      cyc();
      start = 0;
      abort = 0;
      chk("ab63_busy", busy, 0);
      chk("ab63_valid", w_valid, 0);
      chk("ab63_done", done, 0);
      chk("ab63_count", block_count, exp_cnt);
      cyc();
      chk("ab63_done2", done, 0);
      chk("ab63_idle", busy, 0);

      blks[0] = rand_blk();
      gen_ref(blks[0]);
      send_block(blks[0]);
      for (int i = 0; i < 40; i++) cyc();
      chk("r40_round", w_round, 40);
      reset_n = 0;
      start = 1;
      msg_block = rand_blk();
      cyc();
      chk("r40_ready", ready, 1);
      chk("r40_busy", busy, 0);
      chk("r40_valid", w_valid, 0);
      chk("r40_round0", w_round, 0);
      chk("r40_data", w_data, 0);
      chk("r40_last", w_last, 0);
      chk("r40_done", done, 0);
      chk("r40_count", block_count, 0);
      reset_n = 1;
      start = 0;
      exp_cnt = 0;
      cyc();
      chk("r40_not_accepted", busy, 0);
      blks[0] = rand_blk();
      gen_ref(blks[0]);
      send_block(blks[0]);
      stream_check("post_rst");
      finish_check("post_rst");

      for (int n = 0; n < 15; n++) begin
         blks[0] = rand_blk();
         gen_ref(blks[0]);
         send_block(blks[0]);
         stream_check($sformatf("rnd%0d", n));
         finish_check("rnd");
      end
      chk("wrap_count", block_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
